// File: rtl/alu_seq_handshake.sv
// Clocked ALU with valid/ready handshakes on both sides, registered result/flags,
// and an iterative shift-add multiplier that occupies the block for WIDTH cycles.
module alu_seq_handshake #(
  parameter int WIDTH   = 16,
  parameter int SHIFT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         opcode,
  input  logic [WIDTH-1:0]   input1,
  input  logic [WIDTH-1:0]   input2,
  input  logic [SHIFT_W-1:0] shiftValue,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               carryFlag,
  output logic               zeroFlag,
  output logic               overFlowFlag
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_SGE   = 4'd4,
    OP_SLL   = 4'd5,
    OP_MUL   = 4'd6,
    OP_SGT   = 4'd7,
    OP_PASSB = 4'd8
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_MUL_BUSY
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   count_q;
  logic [2*WIDTH-1:0] mul_a_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   mul_b_q;
  logic [WIDTH-1:0]   result_q;
  logic               carry_q;
  logic               zero_q;
  logic               ovf_q;
  logic               out_valid_q;

  logic               slot_free;
  logic               accept;
  logic               mul_step;
  logic               mul_last;
  logic [2*WIDTH-1:0] prod_d;

  logic [WIDTH-1:0]   alu_r;
  logic               alu_c;
  logic               alu_v;
  logic [WIDTH:0]     wide;

  // NOTE: in_ready looks at out_ready combinationally so a result can drain and a new op enter in the same cycle.
  assign slot_free = ~out_valid_q | out_ready;
  assign in_ready  = (state_q == S_IDLE) & slot_free;
  assign accept    = in_valid & in_ready;

  // The final shift-add step and the output load share one edge, giving latency WIDTH+1.
  assign mul_step = (count_q != CNT_W'(WIDTH));
  assign mul_last = (count_q >= CNT_W'(WIDTH - 1));
  assign prod_d   = (mul_step & mul_b_q[0]) ? prod_q + mul_a_q : prod_q;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    wide  = '0;
    case (opcode)
      OP_ADD: begin
        wide  = {1'b0, input1} + {1'b0, input2};
        alu_r = wide[WIDTH-1:0];
        alu_c = wide[WIDTH];
        alu_v = (input1[WIDTH-1] == input2[WIDTH-1]) && (alu_r[WIDTH-1] != input1[WIDTH-1]);
      end
      OP_SUB: begin
        wide  = {1'b0, input1} - {1'b0, input2};
        alu_r = wide[WIDTH-1:0];
        alu_c = wide[WIDTH];
        alu_v = (input1[WIDTH-1] != input2[WIDTH-1]) && (alu_r[WIDTH-1] != input1[WIDTH-1]);
      end
      OP_AND:   alu_r = input1 & input2;
      OP_OR:    alu_r = input1 | input2;
      OP_SGE:   alu_r = {{(WIDTH-1){1'b0}}, ($signed(input1) >= $signed(input2))};
      OP_SGT:   alu_r = {{(WIDTH-1){1'b0}}, ($signed(input1) > $signed(input2))};
      OP_PASSB: alu_r = input2;
      OP_SLL: begin
        // Bit WIDTH of the extended shift is the last bit shifted out; shifts past WIDTH yield zero.
        wide  = {1'b0, input1} << shiftValue;
        alu_r = wide[WIDTH-1:0];
        alu_c = wide[WIDTH];
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous, sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      prod_q      <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (opcode == OP_MUL) begin
              mul_a_q <= {{WIDTH{1'b0}}, input1};
              mul_b_q <= input2;
              prod_q  <= '0;
              count_q <= '0;
              state_q <= S_MUL_BUSY;
            end else begin
              result_q    <= alu_r;
              carry_q     <= alu_c;
              zero_q      <= (alu_r == '0);
              ovf_q       <= alu_v;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_MUL_BUSY: begin
          if (mul_step) begin
            prod_q  <= prod_d;
            mul_a_q <= mul_a_q << 1;
            mul_b_q <= mul_b_q >> 1;
            count_q <= count_q + CNT_W'(1);
          end
          // With the output slot occupied the finished product waits here (count parked at WIDTH).
          if (mul_last && slot_free) begin
            result_q    <= prod_d[WIDTH-1:0];
            carry_q     <= |prod_d[2*WIDTH-1:WIDTH];
            zero_q      <= (prod_d[WIDTH-1:0] == '0);
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign carryFlag    = carry_q;
  assign zeroFlag     = zero_q;
  assign overFlowFlag = ovf_q;

endmodule

// File: tb/tb_alu_seq_handshake.sv
// Bench for alu_seq_handshake (WIDTH=16): directed corner cases, handshake scenarios,
// and randomized ops compared against an arithmetic reference model.
module tb_alu_seq_handshake;

  localparam int W  = 16;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    opcode;
  logic [W-1:0]  input1;
  logic [W-1:0]  input2;
  logic [SW-1:0] shiftValue;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          carryFlag;
  logic          zeroFlag;
  logic          overFlowFlag;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         z;
    logic         v;
  } res_t;

  typedef struct {
    string         name;
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [SW-1:0] s;
    res_t          exp;
  } vec_t;

  always #5 clk = ~clk;

  alu_seq_handshake #(.WIDTH(W), .SHIFT_W(SW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .input1       (input1),
    .input2       (input2),
    .shiftValue   (shiftValue),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .carryFlag    (carryFlag),
    .zeroFlag     (zeroFlag),
    .overFlowFlag (overFlowFlag)
  );

  // Reference model: integer arithmetic on unsigned / signed interpretations.
  function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [SW-1:0] s);
    longint ua, ub, sa, sb, full, mask, smax, smin;
    int     sh;
    res_t   m;
    ua   = a;
    ub   = b;
    mask = (longint'(1) << W) - 1;
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -(smax + 1);
    sa   = (ua > smax) ? ua - (mask + 1) : ua;
    sb   = (ub > smax) ? ub - (mask + 1) : ub;
    sh   = int'(s);
    full = 0;
    m    = '0;
    case (op)
      4'd0: begin
        full = ua + ub;
        m.c  = (full > mask);
        m.v  = ((sa + sb) > smax) || ((sa + sb) < smin);
      end
      4'd1: begin
        full = ua - ub;
        m.c  = (ua < ub);
        m.v  = ((sa - sb) > smax) || ((sa - sb) < smin);
      end
      4'd2: full = ua & ub;
      4'd3: full = ua | ub;
      4'd4: full = (sa >= sb) ? 1 : 0;
      4'd5: begin
        if (sh == 0) full = ua;
        else if (sh <= W) begin
          full = ua << sh;
          m.c  = (((ua >> (W - sh)) & 1) == 1);
        end
      end
      4'd6: begin
        full = ua * ub;
        m.c  = (full > mask);
      end
      4'd7: full = (sa > sb) ? 1 : 0;
      4'd8: full = ub;
      default: full = 0;
    endcase
    m.r = W'(full & mask);
    m.z = (m.r == '0);
    return m;
  endfunction

  function automatic res_t observed();
    return {result, carryFlag, zeroFlag, overFlowFlag};
  endfunction

  // Presents one op (out_ready assumed high), scrambles inputs after accept,
  // and reports the result plus latency in cycles from the accepting edge.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [SW-1:0] s, output res_t got, output int lat);
    int guard;
    guard      = 0;
    opcode     = op;
    input1     = a;
    input2     = b;
    shiftValue = s;
    in_valid   = 1'b1;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      total_cnt++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, guard);
      in_valid = 1'b0;
      got      = '0;
      lat      = -1;
      return;
    end
    @(posedge clk); #1;
    in_valid   = 1'b0;
    opcode     = 4'($urandom);
    input1     = W'($urandom);
    input2     = W'($urandom);
    shiftValue = SW'($urandom);
    lat        = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    got = observed();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    opcode    = '0;
    input1    = '0;
    input2    = '0;
    shiftValue = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    total_cnt++;
    if ({out_valid, observed()} !== {1'b0, res_t'('0)})
      $display("FAIL reset_outputs: out_valid=%b r=%h c=%b z=%b v=%b, required all zero",
               out_valid, result, carryFlag, zeroFlag, overFlowFlag);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    vec_t vt[10];
    res_t got;
    int   lat;
    vt[0] = '{"add_wrap",   4'd0,  16'hFFFF, 16'h0001, 5'd0,  '{16'h0000, 1'b1, 1'b1, 1'b0}};
    vt[1] = '{"sub_ovf",    4'd1,  16'h8000, 16'h0001, 5'd0,  '{16'h7FFF, 1'b0, 1'b0, 1'b1}};
    vt[2] = '{"sgt_signed", 4'd7,  16'hFFFF, 16'h0001, 5'd0,  '{16'h0000, 1'b0, 1'b1, 1'b0}};
    vt[3] = '{"sll_1",      4'd5,  16'h8001, 16'h0000, 5'd1,  '{16'h0002, 1'b1, 1'b0, 1'b0}};
    vt[4] = '{"sll_20",     4'd5,  16'h8001, 16'h0000, 5'd20, '{16'h0000, 1'b0, 1'b1, 1'b0}};
    vt[5] = '{"undef_op12", 4'd12, 16'h1234, 16'h5678, 5'd3,  '{16'h0000, 1'b0, 1'b1, 1'b0}};
    vt[6] = '{"sll_16",     4'd5,  16'h8001, 16'h0000, 5'd16, '{16'h0000, 1'b1, 1'b1, 1'b0}};
    vt[7] = '{"sge_equal",  4'd4,  16'h8000, 16'h8000, 5'd0,  '{16'h0001, 1'b0, 1'b0, 1'b0}};
    vt[8] = '{"add_ovf",    4'd0,  16'h7FFF, 16'h0001, 5'd0,  '{16'h8000, 1'b0, 1'b0, 1'b1}};
    vt[9] = '{"sub_borrow", 4'd1,  16'h0001, 16'h0002, 5'd0,  '{16'hFFFF, 1'b1, 1'b0, 1'b0}};
    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].s, got, lat);
      total_cnt++;
      if (got !== vt[i].exp || lat != 1)
        $display("FAIL %s: got r=%h c=%b z=%b v=%b lat=%0d, required r=%h c=%b z=%b v=%b lat=1",
                 vt[i].name, got.r, got.c, got.z, got.v, lat,
                 vt[i].exp.r, vt[i].exp.c, vt[i].exp.z, vt[i].exp.v);
      else pass_cnt++;
    end
  endtask

  task automatic test_mul();
    int   busy_bad;
    res_t exp;
    drain();
    busy_bad   = 0;
    opcode     = 4'd6;
    input1     = 16'h0100;
    input2     = 16'h0100;
    shiftValue = '0;
    in_valid   = 1'b1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL mul_ready_before: got %b, required 1", in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b1;
    input1   = 16'h0003;
    input2   = 16'h0005;
    for (int k = 0; k < 16; k++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_bad++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total_cnt++;
    if (busy_bad != 0) $display("FAIL mul_busy: %0d busy cycles showed in_ready/out_valid high, required 0", busy_bad);
    else pass_cnt++;
    exp = '{16'h0000, 1'b1, 1'b1, 1'b0};
    total_cnt++;
    if ({out_valid, observed()} !== {1'b1, exp})
      $display("FAIL mul_result: got ov=%b r=%h c=%b z=%b v=%b, required ov=1 r=0000 c=1 z=1 v=0",
               out_valid, result, carryFlag, zeroFlag, overFlowFlag);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int   hold_bad;
    res_t add_exp;
    res_t sub_exp;
    drain();
    hold_bad   = 0;
    add_exp    = '{16'h2345, 1'b0, 1'b0, 1'b0};
    sub_exp    = '{16'h4FFF, 1'b0, 1'b0, 1'b0};
    out_ready  = 1'b0;
    opcode     = 4'd0;
    input1     = 16'h1234;
    input2     = 16'h1111;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    opcode = 4'd1;
    input1 = 16'h5000;
    input2 = 16'h0001;
    for (int k = 0; k < 5; k++) begin
      if (out_valid !== 1'b1 || observed() !== add_exp || in_ready !== 1'b0) hold_bad++;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (hold_bad != 0) $display("FAIL bp_hold: %0d stalled cycles unstable or in_ready high, required 0", hold_bad);
    else pass_cnt++;
    out_ready = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b, required 1", in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total_cnt++;
    if ({out_valid, observed()} !== {1'b1, sub_exp})
      $display("FAIL bp_next_op: got ov=%b r=%h c=%b z=%b v=%b, required ov=1 r=4fff c=0 z=0 v=0",
               out_valid, result, carryFlag, zeroFlag, overFlowFlag);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    res_t exp;
    int   bad;
    drain();
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      opcode     = 4'($urandom_range(0, 5) == 5 ? 8 : $urandom_range(0, 5));
      input1     = W'($urandom);
      input2     = W'($urandom);
      shiftValue = SW'($urandom);
      in_valid   = 1'b1;
      exp        = model(opcode, input1, input2, shiftValue);
      if (in_ready !== 1'b1) bad++;
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || observed() !== exp) bad++;
    end
    in_valid = 1'b0;
    total_cnt++;
    if (bad != 0) $display("FAIL back_to_back: %0d stalled or wrong results in 8 ops, required 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_mul_reset();
    int seen;
    drain();
    seen       = 0;
    opcode     = 4'd6;
    input1     = 16'hFFFF;
    input2     = 16'hFFFF;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total_cnt++;
    if ({out_valid, in_ready, observed()} !== {1'b0, 1'b1, res_t'('0)})
      $display("FAIL mul_abort: got ov=%b rdy=%b r=%h c=%b z=%b v=%b, required ov=0 rdy=1 r=0000 flags 0",
               out_valid, in_ready, result, carryFlag, zeroFlag, overFlowFlag);
    else pass_cnt++;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total_cnt++;
    if (seen != 0) $display("FAIL mul_stale: out_valid high %0d cycles after abort, required 0", seen);
    else pass_cnt++;
  endtask

  task automatic test_random();
    res_t got;
    res_t exp;
    int   lat;
    int   exp_lat;
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [SW-1:0] s;
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = W'($urandom);
      b  = W'($urandom);
      s  = SW'($urandom);
      if ($urandom_range(0, 3) == 0) a = (i % 2 == 0) ? 16'h8000 : 16'h7FFF;
      exp     = model(op, a, b, s);
      exp_lat = (op == 4'd6) ? W + 1 : 1;
      run_op(op, a, b, s, got, lat);
      total_cnt++;
      if (got !== exp || lat != exp_lat)
        $display("FAIL random_%0d op=%0d a=%h b=%h s=%0d: got r=%h c=%b z=%b v=%b lat=%0d, required r=%h c=%b z=%b v=%b lat=%0d",
                 i, op, a, b, s, got.r, got.c, got.z, got.v, lat, exp.r, exp.c, exp.z, exp.v, exp_lat);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_mul_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
